// File: rtl/avalon_st_symbol_unpacker.sv
// Avalon-ST width adapter: splits each captured 24-bit beat into 8-bit symbols,
// trimming trailing empty symbols on end-of-packet beats.
module avalon_st_symbol_unpacker (
   input  logic        clk,
   input  logic        reset,
   output logic        in_ready,
   input  logic        in_valid,
   input  logic [23:0] in_data,
   input  logic        in_startofpacket,
   input  logic        in_endofpacket,
   input  logic [1:0]  in_empty,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [7:0]  out_data,
   output logic        out_startofpacket,
   output logic        out_endofpacket
);

   // Empty of 3 would leave no symbol, so it is clamped to keep one.
   function automatic logic [1:0] sym_count(input logic eop, input logic [1:0] empty);
      logic [1:0] cnt;
      if (!eop) begin
         cnt = 2'd3;
      end else if (empty == 2'd3) begin
         cnt = 2'd1;
      end else begin
         cnt = 2'd3 - empty;
      end
      return cnt;
   endfunction

   logic [23:0] data_q, data_d;
   logic        sop_q, sop_d;
   logic        eop_q, eop_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [1:0]  idx_q, idx_d;
   logic        full_q, full_d;
   logic        last_s;
   logic        in_xfer_s;
   logic        out_xfer_s;

   assign last_s     = (idx_q == (cnt_q - 2'd1));
   assign in_ready   = ~reset & (~full_q | (out_ready & last_s));
   assign in_xfer_s  = in_valid & in_ready;
   assign out_xfer_s = full_q & out_ready;

   // Next-state: a new beat (possibly arriving as the last symbol leaves) wins over symbol advance.
   always_comb begin
      data_d = data_q;
      sop_d  = sop_q;
      eop_d  = eop_q;
      cnt_d  = cnt_q;
      idx_d  = idx_q;
      full_d = full_q;
      if (in_xfer_s) begin
         data_d = in_data;
         sop_d  = in_startofpacket;
         eop_d  = in_endofpacket;
         cnt_d  = sym_count(in_endofpacket, in_empty);
         idx_d  = 2'd0;
         full_d = 1'b1;
      end else if (out_xfer_s) begin
         if (last_s) begin
            full_d = 1'b0;
         end else begin
            idx_d = idx_q + 2'd1;
         end
      end else begin
         full_d = full_q;
      end
   end

   // State registers; reset drops any captured beat immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q <= 24'd0;
         sop_q  <= 1'b0;
         eop_q  <= 1'b0;
         cnt_q  <= 2'd3;
         idx_q  <= 2'd0;
         full_q <= 1'b0;
      end else begin
         data_q <= data_d;
         sop_q  <= sop_d;
         eop_q  <= eop_d;
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         full_q <= full_d;
      end
   end

   // Symbol select: first symbol sits in the most significant byte.
   always_comb begin
      case (idx_q)
         2'd0:    out_data = data_q[23:16];
         2'd1:    out_data = data_q[15:8];
         2'd2:    out_data = data_q[7:0];
         default: out_data = 8'd0;
      endcase
   end

   assign out_valid         = full_q;
   assign out_startofpacket = full_q & sop_q & (idx_q == 2'd0);
   assign out_endofpacket   = full_q & eop_q & last_s;

endmodule

// File: tb/tb_avalon_st_symbol_unpacker.sv
// Bench for avalon_st_symbol_unpacker: directed scenarios plus random traffic,
// checked against a queue of symbols still owed by the captured beat.
module tb_avalon_st_symbol_unpacker;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_ready;
   logic        in_valid = 1'b0;
   logic [23:0] in_data = 24'd0;
   logic        in_startofpacket = 1'b0;
   logic        in_endofpacket = 1'b0;
   logic [1:0]  in_empty = 2'd0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_startofpacket;
   logic        out_endofpacket;

   int checks = 0;
   int errors = 0;
   int beats_acc = 0;

   typedef struct packed {
      logic [7:0] d;
      logic       s;
      logic       e;
   } sym_t;

   sym_t q[$];

   avalon_st_symbol_unpacker dut (
      .clk               (clk),
      .reset             (reset),
      .in_ready          (in_ready),
      .in_valid          (in_valid),
      .in_data           (in_data),
      .in_startofpacket  (in_startofpacket),
      .in_endofpacket    (in_endofpacket),
      .in_empty          (in_empty),
      .out_ready         (out_ready),
      .out_valid         (out_valid),
      .out_data          (out_data),
      .out_startofpacket (out_startofpacket),
      .out_endofpacket   (out_endofpacket)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_now(input logic [7:0] d, input logic s, input logic e);
      chk("now_valid", {7'd0, out_valid}, 8'd1);
      chk("now_data", out_data, d);
      chk("now_sop", {7'd0, out_startofpacket}, {7'd0, s});
      chk("now_eop", {7'd0, out_endofpacket}, {7'd0, e});
   endtask

   // The beat's symbols as the source is owed them: count from eop/empty, sop on first, eop on last.
   task automatic push_beat(input logic [23:0] d, input logic s, input logic e, input logic [1:0] emp);
      int n;
      sym_t y;
      n = !e ? 3 : (emp == 2'd3 ? 1 : 3 - int'(emp));
      for (int k = 0; k < n; k++) begin
         y.d = d[23 - 8*k -: 8];
         y.s = s && (k == 0);
         y.e = e && (k == n - 1);
         q.push_back(y);
      end
   endtask

   task automatic sample_and_check(output logic ixf, output logic oxf);
      logic exp_rdy;
      exp_rdy = !reset && (q.size() == 0 || (out_ready && q.size() == 1));
      chk("in_ready", {7'd0, in_ready}, {7'd0, exp_rdy});
      chk("out_valid", {7'd0, out_valid}, {7'd0, q.size() != 0});
      if (q.size() != 0) begin
         chk("out_data", out_data, q[0].d);
         chk("out_sop", {7'd0, out_startofpacket}, {7'd0, q[0].s});
         chk("out_eop", {7'd0, out_endofpacket}, {7'd0, q[0].e});
      end else if (reset) begin
         chk("rst_data", out_data, 8'd0);
         chk("rst_sop", {7'd0, out_startofpacket}, 8'd0);
         chk("rst_eop", {7'd0, out_endofpacket}, 8'd0);
      end
      ixf = in_valid && exp_rdy;
      oxf = (q.size() != 0) && out_ready;
   endtask

   task automatic step(input logic iv, input logic [23:0] d, input logic s, input logic e,
                       input logic [1:0] emp, input logic ordy);
      logic ixf, oxf;
      in_valid         = iv;
      in_data          = d;
      in_startofpacket = s;
      in_endofpacket   = e;
      in_empty         = emp;
      out_ready        = ordy;
      @(negedge clk);
      sample_and_check(ixf, oxf);
      @(posedge clk);
      if (oxf) void'(q.pop_front());
      if (ixf) begin
         push_beat(d, s, e, emp);
         beats_acc++;
      end
      #1;
   endtask

   initial begin
      // Held in reset for a few edges, then released just after an edge.
      step(1'b1, 24'h123456, 1'b1, 1'b1, 2'd0, 1'b1);
      step(1'b0, 24'h0, 1'b0, 1'b0, 2'd0, 1'b1);
      reset = 1'b0;
      step(1'b0, 24'h0, 1'b0, 1'b0, 2'd0, 1'b1);

      // Single-beat packet.
      step(1'b1, 24'hAABBCC, 1'b1, 1'b1, 2'd0, 1'b1);
      chk_now(8'hAA, 1'b1, 1'b0);
      step(1'b0, 24'h0, 1'b0, 1'b0, 2'd0, 1'b1);
      chk_now(8'hBB, 1'b0, 1'b0);
      step(1'b0, 24'h0, 1'b0, 1'b0, 2'd0, 1'b1);
      chk_now(8'hCC, 1'b0, 1'b1);
      step(1'b0, 24'h0, 1'b0, 1'b0, 2'd0, 1'b1);

      // Empty trim of 2 and 1.
      step(1'b1, 24'h112233, 1'b1, 1'b1, 2'd2, 1'b1);
      chk_now(8'h11, 1'b1, 1'b1);
      step(1'b0, 24'h0, 1'b0, 1'b0, 2'd0, 1'b1);
      chk("trim2_done", {7'd0, out_valid}, 8'd0);
      step(1'b1, 24'h112233, 1'b1, 1'b1, 2'd1, 1'b1);
      chk_now(8'h11, 1'b1, 1'b0);
      step(1'b0, 24'h0, 1'b0, 1'b0, 2'd0, 1'b1);
      chk_now(8'h22, 1'b0, 1'b1);
      step(1'b0, 24'h0, 1'b0, 1'b0, 2'd0, 1'b1);

      // Empty of 3 clamps to one symbol.
      step(1'b1, 24'hDDEEFF, 1'b1, 1'b1, 2'd3, 1'b1);
      chk_now(8'hDD, 1'b1, 1'b1);
      step(1'b0, 24'h0, 1'b0, 1'b0, 2'd0, 1'b1);
      chk("clamp_done", {7'd0, out_valid}, 8'd0);

      // Four back-to-back beats.
      beats_acc = 0;
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 24'h010203 + 24'(beats_acc) * 24'h030303, beats_acc == 0, beats_acc == 3,
              2'd0, 1'b1);
      end
      chk("stream_beats", 8'(beats_acc), 8'd4);
      for (int i = 0; i < 3; i++) step(1'b0, 24'h0, 1'b0, 1'b0, 2'd0, 1'b1);

      // Backpressure at idx 1 for 5 cycles.
      step(1'b1, 24'hA1B2C3, 1'b1, 1'b0, 2'd0, 1'b1);
      step(1'b0, 24'h0, 1'b0, 1'b0, 2'd0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 24'h999999, 1'b0, 1'b1, 2'd0, 1'b0);
         chk_now(8'hB2, 1'b0, 1'b0);
      end
      step(1'b0, 24'h0, 1'b0, 1'b0, 2'd0, 1'b1);
      chk_now(8'hC3, 1'b0, 1'b0);
      step(1'b0, 24'h0, 1'b0, 1'b0, 2'd0, 1'b1);

      // Reset mid-beat, asserted between edges.
      step(1'b1, 24'h445566, 1'b1, 1'b1, 2'd0, 1'b1);
      step(1'b0, 24'h0, 1'b0, 1'b0, 2'd0, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_valid", {7'd0, out_valid}, 8'd0);
      chk("midrst_ready", {7'd0, in_ready}, 8'd0);
      chk("midrst_data", out_data, 8'd0);
      q.delete();
      @(posedge clk);
      #1;
      step(1'b1, 24'h0, 1'b0, 1'b0, 2'd0, 1'b1);
      reset = 1'b0;
      step(1'b1, 24'h778899, 1'b1, 1'b1, 2'd0, 1'b1);
      chk_now(8'h77, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 24'h0, 1'b0, 1'b0, 2'd0, 1'b1);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom), 24'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
              $urandom_range(0, 9) < 7);
      end
      for (int i = 0; i < 4; i++) step(1'b0, 24'h0, 1'b0, 1'b0, 2'd0, 1'b1);
      chk("drained", {7'd0, out_valid}, 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/avalon_st_symbol_unpacker.md
AVALON_ST_SYMBOL_UNPACKER -- requirements
Module: avalon_st_symbol_unpacker

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL have no parameters: 24-bit input beat, 3 symbols of 8 bits each, 1 symbol per output beat.
REQ-003 The ports SHALL be, clock and reset first:
- clk  in  1  rising-edge clock for all state
- reset  in  1  asynchronous active-high reset
- in_ready  out  1  sink ready
- in_valid  in  1  sink beat valid
- in_data  in  24  three symbols, first symbol in [23:16], last in [7:0]
- in_startofpacket  in  1  beat is first of packet
- in_endofpacket  in  1  beat is last of packet
- in_empty  in  2  unused trailing symbols; meaningful only when in_endofpacket=1
- out_ready  in  1  source ready
- out_valid  out  1  source symbol valid
- out_data  out  8  one symbol
- out_startofpacket  out  1  symbol is first of packet
- out_endofpacket  out  1  symbol is last of packet

Function
REQ-004 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; an output transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-005 The block SHALL hold one captured beat (data, sop, eop, symbol count) plus a 2-bit symbol index idx and a full flag.
REQ-006 Symbol count SHALL be 3 for non-EOP beats (in_empty ignored) and 3-in_empty for EOP beats; in_empty=3 on an EOP beat SHALL be treated as 2, giving 1 symbol.
REQ-007 States: EMPTY (full=0) and HOLD (full=1); EMPTY->HOLD on input transfer, HOLD->EMPTY on output transfer of the last symbol with no simultaneous input transfer, HOLD->HOLD on reload.
REQ-008 out_valid SHALL equal full; out_data SHALL be captured byte idx (idx 0 -> [23:16], 1 -> [15:8], 2 -> [7:0]).
REQ-009 out_startofpacket SHALL be 1 only when idx=0 and captured sop=1.
REQ-010 out_endofpacket SHALL be 1 only when idx=count-1 and captured eop=1.
REQ-011 in_ready SHALL be (full=0) OR (out_ready=1 AND idx=count-1), so that a new beat loads in the same edge the last symbol leaves; this is a combinational path from out_ready.
REQ-012 On input transfer, idx SHALL load 0; on an output transfer that is not the last symbol, idx SHALL increment by 1; otherwise idx SHALL hold.
REQ-013 Latency: a beat accepted at edge N SHALL present its first symbol with out_valid=1 in the cycle following edge N.
REQ-014 Throughput: with out_ready held at 1 and in_valid continuously 1, out_valid SHALL stay 1 with no bubbles, with each beat taking count cycles.
REQ-015 Backpressure: while out_ready=0, out_valid, out_data, out_startofpacket, out_endofpacket and idx SHALL remain stable.
REQ-016 The block SHALL NOT check packet framing; SOP/EOP SHALL pass through as captured.

Reset
REQ-017 While reset=1, full=0, idx=0, out_valid=0 and in_ready=0 SHALL hold; out_data, out_startofpacket and out_endofpacket SHALL read 0.
REQ-018 Reset assertion mid-beat SHALL discard the captured beat and any remaining symbols immediately, without waiting for a clock edge.
REQ-019 On the first cycle after reset deasserts, in_ready SHALL be 1 and out_valid 0.

Verification
REQ-020 Single-beat packet: in_data=0xAABBCC, sop=1, eop=1, empty=0, out_ready=1 -> out_data AA(sop=1), BB, CC(eop=1) on 3 consecutive cycles.
REQ-021 Empty trim: EOP beat 0x112233 with empty=2 -> exactly one symbol 0x11 with eop=1; the same beat with empty=1 -> 0x11, 0x22(eop=1).
REQ-022 Streaming: 4 back-to-back beats, out_ready=1 -> 12 symbols with out_valid never 0, and in_ready pulses 1 on every third cycle.
REQ-023 Backpressure: hold out_ready=0 for 5 cycles at idx=1 -> out_data stays byte 1 and in_ready stays 0; on release, the sequence resumes with no loss or duplication.
REQ-024 Reset mid-beat: assert reset after symbol 0 is sent -> out_valid=0 at once; after release, the next beat starts at idx 0.
REQ-025 Illegal empty: eop=1 with empty=3 on 0xDDEEFF -> exactly one symbol 0xDD with sop=1 (if set) and eop=1.
